sr_array_driver: RTL and testbench
==================================

Name: sr_array_driver

Overview:
- Controller that drives an array of SR flip-flops; it is the command side of the SR storage element.
- Accepts a target bit vector over a valid/ready handshake and samples the array's current Q.
- Derives per-bit S/R pulses from the SR excitation table, drives them for one cycle, waits a settle period, then checks that Q equals the target.
- Reports done, plus a per-bit error mask on mismatch.

Parameters:
- WIDTH, 8, number of SR flip-flops driven (min 1).
- SETTLE_CYCLES, 2, idle cycles between the S/R pulse and the Q check (min 0).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tgt_valid  input  1  target vector offered.
- tgt_data  input  WIDTH  desired Q value.
- tgt_ready  output  1  high only in IDLE.
- q_in  input  WIDTH  current Q of the SR array.
- s_out  output  WIDTH  set commands, registered.
- r_out  output  WIDTH  reset commands, registered.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse together with done when any bit mismatches.
- err_mask  output  WIDTH  mismatching bits; held until the next accept.

Behaviour:
- Clock and reset:
  - One clock (clk); reset rst is synchronous and active-high.
  - On rst: state=IDLE; s_out=0, r_out=0, done=0, err=0, err_mask=0, busy=0, tgt_ready=1.
  - rst overrides every other input in the same edge, including mid-DRIVE: pulses drop at that edge and no done is emitted.
- Excitation per bit (cur -> tgt : S,R):
  - 0->0 : 0,0
  - 0->1 : 1,0
  - 1->0 : 0,1
  - 1->1 : 0,0
  - S and R are never both 1, under any input.
- States: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - On an edge with tgt_valid=1, the block registers tgt_data and q_in and computes s_next/r_next.
  - If any S or R bit is 1: go to DRIVE.
  - If all S and R bits are 0 (target already equals Q): go straight to CHECK; no pulse is issued.
- DRIVE:
  - s_out/r_out hold the computed values for exactly one cycle.
  - Next state: SETTLE if SETTLE_CYCLES>0, else CHECK.
  - Counter loads SETTLE_CYCLES-1.
- SETTLE: s_out=r_out=0; count down; at 0 go to CHECK.
- CHECK:
  - Compare q_in with the registered target; mask = q_in XOR target.
  - On the transition to IDLE: done=1 for one cycle; err=|mask; err_mask=mask.
- Latency, counting the accept edge as edge 0:
  - Pulse is visible in cycle 1.
  - CHECK occupies cycle 2+SETTLE_CYCLES.
  - done is visible in cycle 3+SETTLE_CYCLES, i.e. cycle 5 at default.
  - In the no-change case, done is visible in cycle 2.
- Back-to-back and handshake rules:
  - tgt_ready is high in the same cycle as done, so a back-to-back accept on that cycle's closing edge is legal.
  - err_mask clears on that accept.
  - tgt_valid while busy is ignored; no capture occurs.
  - tgt_data only needs to be stable on the accept edge.
- Q sampling: q_in is sampled at accept and at CHECK only; changes on q_in during SETTLE have no effect.

Decomposition:
- Shared package sr_drv_pkg holds:
  - state encoding constants (IDLE=2'd0, DRIVE=2'd1, SETTLE=2'd2, CHECK=2'd3);
  - the excitation-table constants.
- Sub-module sr_excite: purely combinational, WIDTH-parameterised; inputs cur and tgt, outputs s and r per the table above.
- The FSM, counter and handshake stay in sr_array_driver.

Test Plan:
Bench models 8 SR flip-flops whose Q updates one cycle after the S/R pulse; WIDTH=8, SETTLE_CYCLES=2.
1. Q=8'h00, send tgt=8'hA5 -> pulse cycle has s_out=8'hA5, r_out=8'h00; done in cycle 5; err=0; Q=8'hA5.
2. Q=8'hF0, send tgt=8'h3C -> s_out=8'h0C, r_out=8'hC0; done with err=0; s_out&r_out stays 0 in every cycle.
3. Q=8'h5A, send tgt=8'h5A -> no S/R pulse; done in cycle 2; err=0.
4. Model sticks bit 3 at 0, send tgt=8'hFF from 8'h00 -> done=1, err=1, err_mask=8'h08; mask holds until the next accept.
5. Assert rst during DRIVE -> s_out=r_out=0 next edge; busy=0; no done; tgt_ready=1.
6. Hold tgt_valid=1 continuously with alternating values 8'h0F/8'hF0 -> accepts only in IDLE, back-to-back on each done cycle; tgt_valid while busy never captures.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// Purpose: shared FSM encoding and SR excitation table for the SR array driver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    // Excitation entries packed as {s, r}: what to pulse to move cur -> tgt.
    localparam logic [1:0] EXC_HOLD0 = 2'b00;  // 0 -> 0
    localparam logic [1:0] EXC_SET   = 2'b10;  // 0 -> 1
    localparam logic [1:0] EXC_RESET = 2'b01;  // 1 -> 0
    localparam logic [1:0] EXC_HOLD1 = 2'b00;  // 1 -> 1

    // Every row has at most one bit set, so S and R can never both be high.
    function automatic logic [1:0] excite_bit(input logic cur, input logic tgt);
        logic [1:0] sr;
        case ({cur, tgt})
            2'b00:   sr = EXC_HOLD0;
            2'b01:   sr = EXC_SET;
            2'b10:   sr = EXC_RESET;
            default: sr = EXC_HOLD1;
        endcase
        return sr;
    endfunction

endpackage

// File: rtl/sr_excite.sv
// Purpose: per-bit SR excitation, current Q and target Q in, S/R commands out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: cur - present Q; tgt - desired Q; s/r - set/reset commands per bit.
module sr_excite
    import sr_drv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);

    always_comb begin
        s = '0;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {s[i], r[i]} = excite_bit(cur[i], tgt[i]);
        end
    end

endmodule

// File: rtl/sr_array_driver.sv
// Purpose: drives an SR flip-flop array to a target vector and verifies the result.
// Latency: pulse in cycle 1 after accept, done in cycle 3+SETTLE_CYCLES (cycle 2 if no change).
// Backpressure: tgt_ready only in IDLE (including the done cycle); tgt_valid while busy is ignored.
// Ports: clk/rst (sync, active-high); tgt_valid/tgt_ready/tgt_data target handshake;
//        q_in array Q; s_out/r_out registered commands; busy, done, err pulses; err_mask held.
module sr_array_driver
    import sr_drv_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask
);

    // Counter holds SETTLE_CYCLES-1 at most; keep at least one bit so SETTLE_CYCLES
    // of 0 or 1 still elaborates cleanly.
    localparam int              CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int              SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(SETTLE_LOAD);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] tgt_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] s_nxt;
    logic [WIDTH-1:0] r_nxt;
    logic             done_nxt;
    logic             err_nxt;
    logic [WIDTH-1:0] err_mask_nxt;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] exc_s;
    logic [WIDTH-1:0] exc_r;

    // Excitation is evaluated against the live q_in; it only matters on the accept edge.
    sr_excite #(.WIDTH(WIDTH)) u_excite (
        .cur (q_in),
        .tgt (tgt_data),
        .s   (exc_s),
        .r   (exc_r)
    );

    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q    <= '0;
            cnt      <= '0;
            s_out    <= '0;
            r_out    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_mask <= '0;
        end else begin
            tgt_q    <= tgt_nxt;
            cnt      <= cnt_nxt;
            s_out    <= s_nxt;
            r_out    <= r_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            err_mask <= err_mask_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tgt_nxt      = tgt_q;
        cnt_nxt      = cnt;
        s_nxt        = '0;   // commands default low: a pulse lasts exactly one cycle
        r_nxt        = '0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        err_mask_nxt = err_mask;
        mask         = q_in ^ tgt_q;

        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_nxt      = tgt_data;
                    err_mask_nxt = '0;
                    if (|(exc_s | exc_r)) begin
                        s_nxt     = exc_s;
                        r_nxt     = exc_r;
                        state_nxt = DRIVE;
                    end else begin
                        // Array already matches; skip the pulse and settle entirely.
                        state_nxt = CHECK;
                    end
                end
            end
            DRIVE: begin
                cnt_nxt   = CNT_LOAD;
                state_nxt = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            CHECK: begin
                done_nxt     = 1'b1;
                err_nxt      = |mask;
                err_mask_nxt = mask;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_array_driver.sv
// Purpose: directed self-checking bench for sr_array_driver with an 8-bit SR array model.
// Latency: model Q follows the S/R pulse one cycle later.
// Backpressure: bench honours tgt_ready only implicitly via hand-computed accept cycles.
module tb_sr_array_driver;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       tgt_valid = 1'b0;
    logic [7:0] tgt_data  = 8'h00;
    logic       tgt_ready;
    logic [7:0] q_in;
    logic [7:0] s_out;
    logic [7:0] r_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] err_mask;

    // SR array model: load port for test setup, stuck-at-0 mask on the read path.
    logic [7:0] q_arr     = 8'h00;
    logic [7:0] q_set_val = 8'h00;
    logic       q_set     = 1'b0;
    logic [7:0] stuck0    = 8'h00;

    int n_pass      = 0;
    int n_total     = 0;
    int done_cnt    = 0;
    int overlap_cnt = 0;

    sr_array_driver #(.WIDTH(8), .SETTLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_data  (tgt_data),
        .tgt_ready (tgt_ready),
        .q_in      (q_in),
        .s_out     (s_out),
        .r_out     (r_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_mask  (err_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (q_set) q_arr <= q_set_val;
        else       q_arr <= (q_arr & ~r_out) | s_out;
    end

    assign q_in = q_arr & ~stuck0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (|(s_out & r_out)) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_q(input logic [7:0] val);
        q_set     = 1'b1;
        q_set_val = val;
        @(negedge clk);
        q_set     = 1'b0;
    endtask

    // Offers one target for a single edge; returns in cycle 1 after the accept.
    task automatic send(input logic [7:0] val);
        tgt_valid = 1'b1;
        tgt_data  = val;
        @(negedge clk);
        tgt_valid = 1'b0;
        tgt_data  = 8'h99;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (tgt_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(tag, tgt_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] es;
        logic [7:0] er;
        int         d0;

        // Reset, with a target offered to show reset wins.
        rst       = 1'b1;
        tgt_valid = 1'b1;
        tgt_data  = 8'h77;
        cyc(2);
        check("rst_s", s_out, 8'h00);
        check("rst_r", r_out, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_mask", err_mask, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", tgt_ready, 1'b1);
        tgt_valid = 1'b0;
        rst       = 1'b0;
        cyc(1);

        // 1: 00 -> A5
        load_q(8'h00);
        send(8'hA5);
        check("t1_s", s_out, 8'hA5);
        check("t1_r", r_out, 8'h00);
        check("t1_busy", busy, 1'b1);
        check("t1_ready", tgt_ready, 1'b0);
        cyc(3);
        check("t1_done_c4", done, 1'b0);
        check("t1_busy_c4", busy, 1'b1);
        cyc(1);
        check("t1_done_c5", done, 1'b1);
        check("t1_err", err, 1'b0);
        check("t1_mask", err_mask, 8'h00);
        check("t1_ready_c5", tgt_ready, 1'b1);
        cyc(1);
        check("t1_done_c6", done, 1'b0);
        check("t1_q", q_in, 8'hA5);

        // 2: F0 -> 3C
        load_q(8'hF0);
        send(8'h3C);
        check("t2_s", s_out, 8'h0C);
        check("t2_r", r_out, 8'hC0);
        cyc(4);
        check("t2_done", done, 1'b1);
        check("t2_err", err, 1'b0);
        cyc(1);
        check("t2_q", q_in, 8'h3C);

        // 3: no change, done in cycle 2
        load_q(8'h5A);
        send(8'h5A);
        check("t3_s", s_out, 8'h00);
        check("t3_r", r_out, 8'h00);
        check("t3_busy", busy, 1'b1);
        check("t3_done_c1", done, 1'b0);
        cyc(1);
        check("t3_done_c2", done, 1'b1);
        check("t3_err", err, 1'b0);
        check("t3_ready", tgt_ready, 1'b1);
        cyc(1);

        // 4: bit 3 stuck at 0
        stuck0 = 8'h08;
        load_q(8'h00);
        send(8'hFF);
        check("t4_s", s_out, 8'hFF);
        cyc(4);
        check("t4_done", done, 1'b1);
        check("t4_err", err, 1'b1);
        check("t4_mask", err_mask, 8'h08);
        cyc(1);
        check("t4_done_off", done, 1'b0);
        check("t4_err_off", err, 1'b0);
        check("t4_mask_hold1", err_mask, 8'h08);
        cyc(3);
        check("t4_mask_hold4", err_mask, 8'h08);
        stuck0 = 8'h00;
        send(8'hFF);
        check("t4_mask_clear", err_mask, 8'h00);
        check("t4b_s", s_out, 8'h00);
        cyc(1);
        check("t4b_done", done, 1'b1);
        check("t4b_err", err, 1'b0);
        cyc(1);

        // 5: reset during DRIVE
        load_q(8'h00);
        d0 = done_cnt;
        send(8'h0F);
        check("t5_s_drive", s_out, 8'h0F);
        rst = 1'b1;
        cyc(1);
        check("t5_s", s_out, 8'h00);
        check("t5_r", r_out, 8'h00);
        check("t5_busy", busy, 1'b0);
        check("t5_ready", tgt_ready, 1'b1);
        check("t5_done", done, 1'b0);
        rst = 1'b0;
        cyc(8);
        check("t5_no_done", done_cnt, d0);
        check("t5_idle", tgt_ready, 1'b1);

        // 6: tgt_valid held high; accepts at edges 0,5,10,15 only
        load_q(8'h00);
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                check("t6_ready", tgt_ready, (c % 5 == 0));
                check("t6_done", done, (c % 5 == 0));
                if (c % 5 == 0) check("t6_err", err, 1'b0);
            end
            if (c % 5 == 1) begin
                case (c / 5)
                    0:       begin es = 8'h0F; er = 8'h00; end
                    1:       begin es = 8'hF0; er = 8'h0F; end
                    2:       begin es = 8'h0F; er = 8'hF0; end
                    default: begin es = 8'hF0; er = 8'h0F; end
                endcase
                check("t6_s", s_out, es);
                check("t6_r", r_out, er);
            end
            tgt_valid = 1'b1;
            if (c % 5 == 0) tgt_data = ((c / 5) % 2 == 0) ? 8'h0F : 8'hF0;
            else            tgt_data = 8'(c * 37 + 1);
            @(negedge clk);
        end
        tgt_valid = 1'b0;
        wait_idle("t6_final_idle");
        check("t6_last_done", done, 1'b1);
        cyc(1);
        check("t6_q", q_in, 8'hF0);

        check("never_s_and_r", overlap_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
